// File: rtl/seq_mult_shift.sv
// Signed radix-2 shift-and-add multiplier for the execute stage.
// Ports: clock, reset (async low), ctrl_mult, data_operandA/B in;
//   data_result, data_resultRDY, data_exception, busy out.
//   Optional early termination: SEQ_MULT_EARLY_TERM_EN.
module seq_mult_shift #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic             busy
);

  typedef enum logic {IDLE, CALC} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  state_t state, state_n;

  logic [2*WIDTH-1:0] mcand, acc, acc_n, prod;
  logic [WIDTH-1:0]   mplier, mplier_n;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [CNT_W-1:0]   cnt;
  logic               sign, start, done, ovf;

  // Magnitudes are unsigned: |0x80000000| stays 0x80000000
  assign mag_a = data_operandA[WIDTH-1] ? -data_operandA
                                        : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? -data_operandB
                                        : data_operandB;

  assign mplier_n = mplier >> 1;
  assign acc_n    = mplier[0] ? acc + mcand : acc;
  assign prod     = sign ? -acc_n : acc_n;
  assign ovf      = prod[2*WIDTH-1:WIDTH]
                    != {WIDTH{prod[WIDTH-1]}};

  assign start = (state == IDLE) && ctrl_mult;

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign done = (cnt == LAST) || (mplier_n == '0);
`else
  assign done = (cnt == LAST);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    unique case (state)
      IDLE: if (ctrl_mult) state_n = CALC;
      CALC: begin
        busy = 1'b1;
        if (done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      cnt            <= '0;
      sign           <= 1'b0;
      data_result    <= '0;
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        mcand          <= {{WIDTH{1'b0}}, mag_a};
        mplier         <= mag_b;
        sign           <= data_operandA[WIDTH-1]
                          ^ data_operandB[WIDTH-1];
        acc            <= '0;
        cnt            <= '0;
        data_exception <= 1'b0;
      end else if (state == CALC) begin
        acc    <= acc_n;
        mcand  <= mcand << 1;
        mplier <= mplier_n;
        cnt    <= cnt + CNT_W'(1);
        if (done) begin
          data_result    <= prod[WIDTH-1:0];
          data_exception <= ovf;
          data_resultRDY <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_shift.sv
// Randomized self-checking bench for seq_mult_shift.
// Reference: 64-bit signed product and bit-length latency.
module tb_seq_mult_shift;

  logic        clock, reset, ctrl_mult;
  logic [31:0] opa, opb;
  logic [31:0] data_result;
  logic        data_resultRDY, data_exception, busy;

  int n_chk  = 0;
  int n_fail = 0;

  seq_mult_shift dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint prod64(input logic [31:0] a,
                                    input logic [31:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  function automatic logic [31:0] exp_res(input logic [31:0] a,
                                          input logic [31:0] b);
    longint p = prod64(a, b);
    return p[31:0];
  endfunction

  function automatic logic exp_exc(input logic [31:0] a,
                                   input logic [31:0] b);
    longint p = prod64(a, b);
    logic [31:0] lo = p[31:0];
    return p != longint'($signed(lo));
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [31:0] m = b[31] ? -b : b;
    int n = 0;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return (n == 0) ? 1 : n;
`else
    return 32;
`endif
  endfunction

  // Called at a negedge; the start is taken at the next posedge (E0).
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    ctrl_mult = 1'b1;
    opa = a;
    opb = b;
    @(negedge clock);
    ctrl_mult = 1'b0;
    opa = $urandom;
    opb = $urandom;
    chk("busy_start", {63'd0, busy}, 64'd1);
  endtask

  // Returns at the negedge where the ready pulse is visible.
  task automatic wait_done(input logic [31:0] a,
                           input logic [31:0] b,
                           input int inject_at);
    int n = 0;
    logic busy_ok = 1'b1;
    while (!data_resultRDY && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clock);
      n++;
      ctrl_mult = (n == inject_at);
      if (n == inject_at) begin
        opa = 32'd9;
        opb = 32'd9;
      end
    end
    ctrl_mult = 1'b0;
    chk("busy_during", {63'd0, busy_ok}, 64'd1);
    chk("latency", 64'(n), 64'(exp_lat(b)));
    chk("result", {32'd0, data_result}, {32'd0, exp_res(a, b)});
    chk("exception", {63'd0, data_exception},
        {63'd0, exp_exc(a, b)});
    chk("busy_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic full_op(input logic [31:0] a, input logic [31:0] b);
    launch(a, b);
    wait_done(a, b, 0);
    @(negedge clock);
    chk("rdy_pulse", {63'd0, data_resultRDY}, 64'd0);
    chk("result_hold", {32'd0, data_result}, {32'd0, exp_res(a, b)});
    chk("exc_hold", {63'd0, data_exception},
        {63'd0, exp_exc(a, b)});
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom & 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    logic saw_rdy;
    reset     = 1'b0;
    ctrl_mult = 1'b0;
    opa       = '0;
    opb       = '0;
    repeat (2) @(negedge clock);
    chk("rst_result", {32'd0, data_result}, 64'd0);
    chk("rst_rdy", {63'd0, data_resultRDY}, 64'd0);
    chk("rst_exc", {63'd0, data_exception}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    full_op(32'd3, 32'd5);
    full_op(-32'sd7, 32'd6);
    full_op(32'h0001_0000, 32'h0001_0000);
    full_op(32'h8000_0000, 32'hFFFF_FFFF);
    full_op(32'h8000_0000, 32'h0000_0001);
    full_op(32'd123, 32'd0);

    // Start at the ready-pulse cycle is accepted
    launch(32'd11, 32'd13);
    wait_done(32'd11, 32'd13, 0);
    launch(-32'sd4, 32'd25);
    chk("b2b_rdy_low", {63'd0, data_resultRDY}, 64'd0);
    wait_done(-32'sd4, 32'd25, 0);
    @(negedge clock);

    // Start request while busy is ignored
    launch(32'd3, 32'd5);
    wait_done(32'd3, 32'd5, 10);
    @(negedge clock);

    // Asynchronous reset mid-operation
    launch(32'h1234_5678, 32'h0000_FFFF);
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort_result", {32'd0, data_result}, 64'd0);
    chk("abort_rdy", {63'd0, data_resultRDY}, 64'd0);
    chk("abort_exc", {63'd0, data_exception}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    saw_rdy = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY || busy) saw_rdy = 1'b1;
    end
    chk("no_rdy_after_rst", {63'd0, saw_rdy}, 64'd0);
    full_op(32'd100, -32'sd3);

    for (int i = 0; i < 24; i++) begin
      a = pick();
      b = pick();
      full_op(a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult_shift.md
Name: seq_mult_shift

Overview:
- Multicycle signed 32x32 radix-2 shift-and-add multiplier for the execute stage.
- Consumes the same shift-left-by-one operation the barrel shifter produces: each cycle the multiplicand is shifted left one bit and conditionally accumulated.
- Sits beside the ALU/shifter. The stall logic holds the pipeline while busy is high.
- Returns a 32-bit product, a one-cycle ready pulse, and an overflow exception.

Parameters:
- WIDTH, 32, operand/result width; the product accumulator is 2*WIDTH. Only 32 is verified.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- ctrl_mult  input  1  start request; sampled only in IDLE
- data_operandA  input  WIDTH  multiplicand, two's complement
- data_operandB  input  WIDTH  multiplier, two's complement
- data_result  output  WIDTH  low WIDTH bits of the signed product
- data_resultRDY  output  1  one-cycle pulse; result valid
- data_exception  output  1  signed overflow flag; valid with data_resultRDY and held until the next start
- busy  output  1  high from start acceptance until the ready pulse

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; data_result=0, data_resultRDY=0, data_exception=0, busy=0; all internal registers cleared.
- Reset mid-operation aborts immediately; no ready pulse follows.
- States: IDLE, CALC.
- IDLE, at edge E0 with ctrl_mult=1:
  - latch mcand=|A| (zero-extended to 2*WIDTH) and mplier=|B|;
  - sign=A[31]^B[31]; acc=0; cnt=0;
  - busy=1; go to CALC;
  - data_resultRDY drops to 0 at this edge if it was high.
- CALC, each edge:
  - if mplier[0]: acc=acc+mcand (2*WIDTH add, carry discarded);
  - mcand<<=1; mplier>>=1 (logical); cnt=cnt+1.
- CALC termination: the edge where cnt reaches WIDTH-1, i.e. the 32nd CALC edge, E32. At that edge:
  - final value P = sign ? -(acc_next) : acc_next, in 2*WIDTH bits;
  - data_result = P[31:0];
  - data_exception = 1 iff P[63:32] is not all copies of P[31];
  - data_resultRDY = 1; busy = 0; go to IDLE.
- Latency: ready observed high in the cycle after E32 and low after E33 (one-cycle pulse). data_result holds until the next accepted start.
- ctrl_mult while busy: ignored, not queued.
- ctrl_mult at the same edge as the ready pulse cycle (state already IDLE): accepted normally.
- |0x80000000| is 0x80000000 treated unsigned; this is correct because mcand/mplier are unsigned magnitudes.
- Operand inputs are sampled only at E0; later changes have no effect.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: CALC also terminates at the first edge where the post-shift mplier is zero, whichever comes first.
  - Minimum one CALC edge.
  - Ready follows that edge; result and exception rules unchanged.
  - Example: |B|=5 finishes at E3; B=0 finishes at E1.
- Undefined: fixed 32-edge latency regardless of operands.

Test Plan:
- A=3, B=5, start at E0 -> ready after E32 for one cycle; data_result=0x0000000F, exception=0, busy high E0..E32.
- A=-7, B=6 -> data_result=0xFFFFFFD6, exception=0.
- A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1.
- A=0x80000000, B=0xFFFFFFFF -> exception=1. Also A=0x80000000, B=1 -> data_result=0x80000000, exception=0.
- Start 3x5, pulse ctrl_mult with A=9, B=9 at E10, then assert reset=0 mid-way through a second accepted op -> the first result is still 15 at E32 (E10 start ignored). After reset: all outputs 0, busy=0, no ready pulse; a new start completes normally.
- With SEQ_MULT_EARLY_TERM_EN: A=3, B=5 -> ready after E3, result 15; A=123, B=0 -> ready after E1, result 0. Without the macro, both cases are ready after E32.
